// File: rtl/cnn_loop_pkg.sv
// Shared types and helpers for the nested loop counter.
// Loop mode selection and the packed-slice index used by the per-level bus packing.
package cnn_loop_pkg;

  typedef enum logic {
    ModeOneshot,
    ModeFreerun
  } loop_mode_e;

  // Low bit of level `level` within a bus packed as level i at [i*width +: width].
  function automatic int unsigned slice_lo(input int unsigned level, input int unsigned width);
    return level * width;
  endfunction

  function automatic loop_mode_e mode_from_param(input int unsigned oneshot);
    return (oneshot != 0) ? ModeOneshot : ModeFreerun;
  endfunction

endpackage

// File: rtl/loop_level.sv
// One level of the nested loop counter: latched max/stride, a count register and a wrap pulse.
// A level advances only on carry_in and forwards a carry when it is at its final value.
module loop_level
  import cnn_loop_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  carry_in,
  input  logic [DATA_WIDTH-1:0] cfg_max,
  input  logic [DATA_WIDTH-1:0] cfg_stride,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  last,
  output logic                  carry_out,
  output logic                  wrap
);

  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] max_q;
  logic [DATA_WIDTH-1:0] stride_q;
  logic                  wrap_q, wrap_d;
  logic [DATA_WIDTH:0]   sum;

  // One extra bit so count + stride can never overflow before the compare.
  assign sum  = {1'b0, count_q} + {1'b0, stride_q};
  assign last = (stride_q == '0) | (sum > {1'b0, max_q});

  assign carry_out = carry_in & last;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (carry_in) begin
      count_d = last ? '0 : sum[DATA_WIDTH-1:0];
      wrap_d  = last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      max_q    <= '0;
      stride_q <= '0;
      wrap_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (load) begin
      count_q  <= '0;
      max_q    <= cfg_max;
      stride_q <= cfg_stride;
      wrap_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= max_q);
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/nested_loop_count.sv
// N-level nested loop counter: a carry chain of loop_level instances, level 0 innermost,
// with busy/done control and optional halt after the full iteration space.
module nested_loop_count
  import cnn_loop_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned NUM_LEVELS = 3,
  parameter int unsigned ONESHOT    = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             start,
  input  logic                             step,
  input  logic [NUM_LEVELS*DATA_WIDTH-1:0] max,
  input  logic [NUM_LEVELS*DATA_WIDTH-1:0] stride,
  output logic [NUM_LEVELS*DATA_WIDTH-1:0] count,
  output logic [NUM_LEVELS-1:0]            last,
  output logic [NUM_LEVELS-1:0]            wrap,
  output logic                             done,
  output logic                             busy
);

  localparam loop_mode_e Mode = mode_from_param(ONESHOT);

  logic [NUM_LEVELS:0] carry;
  logic                busy_q;
  logic                done_q;

  // Start and clear take priority, so no step is accepted in those cycles.
  assign carry[0] = step & busy_q & ~start & ~clear;

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : gen_level
    localparam int unsigned Lo = slice_lo(g, DATA_WIDTH);

    loop_level #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_level (
      .clk       (clk),
      .reset     (reset),
      .clr       (clear),
      .load      (start),
      .carry_in  (carry[g]),
      .cfg_max   (max[Lo +: DATA_WIDTH]),
      .cfg_stride(stride[Lo +: DATA_WIDTH]),
      .count     (count[Lo +: DATA_WIDTH]),
      .last      (last[g]),
      .carry_out (carry[g+1]),
      .wrap      (wrap[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (clear) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= carry[NUM_LEVELS];
      if ((Mode == ModeOneshot) && carry[NUM_LEVELS]) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_nested_loop_count.sv
// Directed bench for nested_loop_count: a one-shot and a free-running instance share stimulus.
module tb_nested_loop_count;

  localparam int unsigned DW = 4;
  localparam int unsigned N  = 2;

  logic          clk = 1'b0;
  logic          reset, clear, start, step;
  logic [N*DW-1:0] max_in, stride_in;
  logic [N*DW-1:0] count1, count0;
  logic [N-1:0]    last1, last0, wrap1, wrap0;
  logic            done1, done0, busy1, busy0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nested_loop_count #(.DATA_WIDTH(DW), .NUM_LEVELS(N), .ONESHOT(1)) u_dut_os (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .step(step),
    .max(max_in), .stride(stride_in), .count(count1), .last(last1), .wrap(wrap1),
    .done(done1), .busy(busy1)
  );

  nested_loop_count #(.DATA_WIDTH(DW), .NUM_LEVELS(N), .ONESHOT(0)) u_dut_fr (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .step(step),
    .max(max_in), .stride(stride_in), .count(count0), .last(last0), .wrap(wrap0),
    .done(done0), .busy(busy0)
  );

  typedef struct {
    logic [3:0] c0;
    logic [3:0] c1;
    logic [1:0] wrap;
    logic [1:0] last;
    logic       done;
    logic       busy_os;
  } row_t;

  row_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick(input logic st, input logic sp);
    start = st;
    step  = sp;
    @(posedge clk);
    #1;
    start = 1'b0;
    step  = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] m, input logic [7:0] s);
    max_in    = m;
    stride_in = s;
    tick(1'b1, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{4'd1, 4'd0, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[1]  = '{4'd2, 4'd0, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[2]  = '{4'd3, 4'd0, 2'b00, 2'b01, 1'b0, 1'b1};
    tbl[3]  = '{4'd0, 4'd1, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[4]  = '{4'd1, 4'd1, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{4'd2, 4'd1, 2'b00, 2'b00, 1'b0, 1'b1};
    tbl[6]  = '{4'd3, 4'd1, 2'b00, 2'b01, 1'b0, 1'b1};
    tbl[7]  = '{4'd0, 4'd2, 2'b01, 2'b10, 1'b0, 1'b1};
    tbl[8]  = '{4'd1, 4'd2, 2'b00, 2'b10, 1'b0, 1'b1};
    tbl[9]  = '{4'd2, 4'd2, 2'b00, 2'b10, 1'b0, 1'b1};
    tbl[10] = '{4'd3, 4'd2, 2'b00, 2'b11, 1'b0, 1'b1};
    tbl[11] = '{4'd0, 4'd0, 2'b11, 2'b00, 1'b1, 1'b0};

    reset = 1'b1; clear = 1'b0; start = 1'b0; step = 1'b0;
    max_in = '0; stride_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state: zero cfg means stride 0, so every level reports last.
    chk("rst_count", {24'd0, count1}, 32'd0);
    chk("rst_busy",  {31'd0, busy1}, 32'd0);
    chk("rst_done",  {31'd0, done1}, 32'd0);
    chk("rst_wrap",  {30'd0, wrap1}, 32'd0);
    chk("rst_last",  {30'd0, last1}, 32'd3);

    // Test 1 / 4: max {2,3}, stride {1,1}, 12 iterations.
    do_start(8'h23, 8'h11);
    chk("t1_busy_start", {31'd0, busy1}, 32'd1);
    chk("t1_count_start", {24'd0, count1}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("t1_os_count[%0d]", k + 1), {24'd0, count1}, {24'd0, tbl[k].c1, tbl[k].c0});
      chk($sformatf("t1_os_wrap[%0d]", k + 1), {30'd0, wrap1}, {30'd0, tbl[k].wrap});
      chk($sformatf("t1_os_last[%0d]", k + 1), {30'd0, last1}, {30'd0, tbl[k].last});
      chk($sformatf("t1_os_done[%0d]", k + 1), {31'd0, done1}, {31'd0, tbl[k].done});
      chk($sformatf("t1_os_busy[%0d]", k + 1), {31'd0, busy1}, {31'd0, tbl[k].busy_os});
      chk($sformatf("t1_fr_count[%0d]", k + 1), {24'd0, count0}, {24'd0, tbl[k].c1, tbl[k].c0});
      chk($sformatf("t1_fr_done[%0d]", k + 1), {31'd0, done0}, {31'd0, tbl[k].done});
      chk($sformatf("t1_fr_busy[%0d]", k + 1), {31'd0, busy0}, 32'd1);
    end
    // Second pass: free-run repeats, one-shot ignores steps.
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b1);
      chk($sformatf("t4_fr_count[%0d]", k + 13), {24'd0, count0}, {24'd0, tbl[k].c1, tbl[k].c0});
      chk($sformatf("t4_fr_wrap[%0d]", k + 13), {30'd0, wrap0}, {30'd0, tbl[k].wrap});
      chk($sformatf("t4_fr_done[%0d]", k + 13), {31'd0, done0}, {31'd0, tbl[k].done});
      chk($sformatf("t4_fr_busy[%0d]", k + 13), {31'd0, busy0}, 32'd1);
      chk($sformatf("t4_os_idle[%0d]", k + 13), {22'd0, busy1, done1, count1}, 32'd0);
    end
    tick(1'b0, 1'b0);
    chk("t4_fr_wrap_idle", {30'd0, wrap0}, 32'd0);
    chk("t4_fr_done_idle", {31'd0, done0}, 32'd0);
    chk("t4_os_last_after", {30'd0, last1}, 32'd0);

    // Test 2: L0 max 7 stride 3 -> 0,3,6,0.
    do_start(8'h17, 8'h13);
    tick(1'b0, 1'b1);
    chk("t2_c_s1", {24'd0, count1}, 32'h03);
    tick(1'b0, 1'b1);
    chk("t2_c_s2", {24'd0, count1}, 32'h06);
    chk("t2_last_s2", {31'd0, last1[0]}, 32'd1);
    chk("t2_wrap_s2", {30'd0, wrap1}, 32'd0);
    tick(1'b0, 1'b1);
    chk("t2_c_s3", {24'd0, count1}, 32'h10);
    chk("t2_wrap_s3", {30'd0, wrap1}, 32'd1);

    // Test 3: max0=0, then stride0=0; every step advances L1.
    do_start(8'h30, 8'h11);
    chk("t3a_last0", {31'd0, last1[0]}, 32'd1);
    tick(1'b0, 1'b1);
    chk("t3a_c", {24'd0, count1}, 32'h10);
    chk("t3a_wrap", {30'd0, wrap1}, 32'd1);
    tick(1'b0, 1'b1);
    chk("t3a_c2", {24'd0, count1}, 32'h20);
    do_start(8'h35, 8'h10);
    chk("t3b_last0", {31'd0, last1[0]}, 32'd1);
    tick(1'b0, 1'b1);
    chk("t3b_c", {24'd0, count1}, 32'h10);
    tick(1'b0, 1'b1);
    chk("t3b_c2", {24'd0, count1}, 32'h20);

    // Test 5a: clear after 5 steps keeps cfg.
    do_start(8'h23, 8'h11);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1);
    chk("t5a_c_pre", {24'd0, count1}, 32'h11);
    clear = 1'b1;
    tick(1'b0, 1'b0);
    clear = 1'b0;
    chk("t5a_c", {24'd0, count1}, 32'd0);
    chk("t5a_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("t5a_last_cfg_kept", {30'd0, last1}, 32'd0);
    tick(1'b0, 1'b1);
    chk("t5a_step_ignored", {24'd0, count1}, 32'd0);

    // Test 5b: reset after 5 steps zeroes cfg.
    do_start(8'h23, 8'h11);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    chk("t5b_c", {24'd0, count1}, 32'd0);
    chk("t5b_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("t5b_last_cfg_zero", {30'd0, last1}, 32'd3);
    tick(1'b0, 1'b1);
    chk("t5b_step_ignored", {24'd0, count1}, 32'd0);

    // Test 6: step in start cycle ignored; restart mid-run; max input change ignored.
    max_in = 8'h23; stride_in = 8'h11;
    tick(1'b1, 1'b1);
    chk("t6_startstep_c", {24'd0, count1}, 32'd0);
    chk("t6_startstep_busy", {31'd0, busy1}, 32'd1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("t6_c2", {24'd0, count1}, 32'h02);
    max_in = 8'h21;
    tick(1'b1, 1'b1);
    chk("t6_restart_c", {24'd0, count1}, 32'd0);
    max_in = 8'hFF;
    tick(1'b0, 1'b1);
    chk("t6_new_c1", {24'd0, count1}, 32'h01);
    chk("t6_new_last0", {31'd0, last1[0]}, 32'd1);
    tick(1'b0, 1'b1);
    chk("t6_new_c2", {24'd0, count1}, 32'h10);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("t6_c4", {24'd0, count1}, 32'h20);
    chk("t6_last4", {30'd0, last1}, 32'd2);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("t6_done", {31'd0, done1}, 32'd1);
    chk("t6_busy_end", {31'd0, busy1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
